// File: rtl/pm_instruction_reader.sv
// Program-memory read side: fetches one instruction word per request, splits it into
// fields and hands it to decode through valid/ready before advancing the PC.
module pm_instruction_reader #(
  parameter int ADDR_W     = 5,
  parameter int INST_W     = 68,
  parameter int RD_LATENCY = 1,
  parameter int LAST_ADDR  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd,
  input  logic [INST_W-1:0] pm_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [2:0]        inst_opcode,
  output logic              inst_mode,
  output logic [31:0]       inst_op_a,
  output logic [31:0]       inst_op_b,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              halted
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] addr_hold;
  logic [CNT_W-1:0]  lat_cnt;
  logic              data_due;
  logic              capture;
  logic              handshake;

  assign data_due  = (state == S_WAIT) && (lat_cnt == CNT_W'(1));
  // A jump in the same cycle as the data return throws the word away.
  assign capture   = data_due && !pc_load;
  assign handshake = (state == S_HOLD) && inst_ready;
  assign pm_addr   = pm_rd ? pc : addr_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pm_rd      = 1'b0;
    inst_valid = 1'b0;
    busy       = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_REQ;
      end
      S_REQ: begin
        pm_rd     = 1'b1;
        busy      = 1'b1;
        state_nxt = pc_load ? S_REQ : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (pc_load) begin
          state_nxt = S_REQ;
        end else if (data_due) begin
          state_nxt = (pm_rdata == '0) ? S_HALT : S_HOLD;
        end
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        busy       = 1'b1;
        if (pc_load) begin
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          state_nxt = (inst_pc == ADDR_W'(LAST_ADDR)) ? S_HALT : S_REQ;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      addr_hold   <= '0;
      lat_cnt     <= '0;
      inst_opcode <= '0;
      inst_mode   <= 1'b0;
      inst_op_a   <= '0;
      inst_op_b   <= '0;
      inst_pc     <= '0;
    end else begin
      // A jump wins over a same-cycle handshake: the word is consumed but PC is not stepped.
      if (pc_load) begin
        pc <= pc_load_addr;
      end else if (handshake) begin
        pc <= pc + ADDR_W'(1);
      end
      if (pm_rd) addr_hold <= pc;
      if (state == S_REQ) begin
        lat_cnt <= CNT_W'(RD_LATENCY);
      end else if ((state == S_WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
      if (capture) begin
        inst_opcode <= pm_rdata[INST_W-1 -: 3];
        inst_mode   <= pm_rdata[INST_W-4];
        inst_op_a   <= pm_rdata[63:32];
        inst_op_b   <= pm_rdata[31:0];
        inst_pc     <= pc;
      end
    end
  end

endmodule

// File: tb/tb_pm_instruction_reader.sv
// Randomised scoreboard bench: a program-walk model predicts fetch addresses and
// presented instructions for a default instance and a short, slow-memory instance.
module tb_pm_instruction_reader;

  typedef struct packed {
    logic [67:0] word;
    logic [4:0]  pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        start_a, pc_load_a, pm_rd_a, inst_valid_a, inst_ready_a;
  logic [4:0]  pc_load_addr_a, pm_addr_a, inst_pc_a;
  logic [67:0] pm_rdata_a;
  logic [2:0]  opcode_a;
  logic        mode_a, busy_a, halted_a;
  logic [31:0] op_a_a, op_b_a;

  logic        start_b, pc_load_b, pm_rd_b, inst_valid_b, inst_ready_b;
  logic [1:0]  pc_load_addr_b, pm_addr_b, inst_pc_b;
  logic [67:0] pm_rdata_b;
  logic [2:0]  opcode_b;
  logic        mode_b, busy_b, halted_b;
  logic [31:0] op_a_b, op_b_b;

  logic [67:0] mem_a [32];
  logic [67:0] mem_b [4];
  logic [67:0] junk = '0;
  logic        rv_a = 1'b0;
  logic [4:0]  ra_a = '0;
  logic [2:0]  rv_b = '0;
  logic [1:0]  ra_b0 = '0, ra_b1 = '0, ra_b2 = '0;

  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  int   adr_q_a[$];
  int   adr_q_b[$];
  int   model_pc_a, model_pc_b;
  int   ready_mode;
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  pm_instruction_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pc_load(pc_load_a),
    .pc_load_addr(pc_load_addr_a), .pm_addr(pm_addr_a), .pm_rd(pm_rd_a),
    .pm_rdata(pm_rdata_a), .inst_valid(inst_valid_a), .inst_ready(inst_ready_a),
    .inst_opcode(opcode_a), .inst_mode(mode_a), .inst_op_a(op_a_a), .inst_op_b(op_b_a),
    .inst_pc(inst_pc_a), .busy(busy_a), .halted(halted_a)
  );

  pm_instruction_reader #(.ADDR_W(2), .INST_W(68), .RD_LATENCY(3), .LAST_ADDR(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pc_load(pc_load_b),
    .pc_load_addr(pc_load_addr_b), .pm_addr(pm_addr_b), .pm_rd(pm_rd_b),
    .pm_rdata(pm_rdata_b), .inst_valid(inst_valid_b), .inst_ready(inst_ready_b),
    .inst_opcode(opcode_b), .inst_mode(mode_b), .inst_op_a(op_a_b), .inst_op_b(op_b_b),
    .inst_pc(inst_pc_b), .busy(busy_b), .halted(halted_b)
  );

  // Memories return real data only in the slot the requested latency implies; junk otherwise.
  always @(posedge clk) begin
    junk  <= {$urandom(), $urandom(), 4'($urandom())};
    rv_a  <= pm_rd_a;
    ra_a  <= pm_addr_a;
    rv_b  <= {rv_b[1:0], pm_rd_b};
    ra_b0 <= pm_addr_b;
    ra_b1 <= ra_b0;
    ra_b2 <= ra_b1;
  end
  assign pm_rdata_a = rv_a ? mem_a[ra_a] : junk;
  assign pm_rdata_b = rv_b[2] ? mem_b[ra_b2] : junk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flagUnexpected(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
  endtask

  function automatic logic [67:0] randWord(input int zero_odds);
    if (zero_odds > 0 && $urandom_range(0, zero_odds - 1) == 0) return '0;
    return {$urandom(), $urandom(), 4'($urandom())} | 68'd1;
  endfunction

  // Reference: walk memory from pc0 until a zero word or the last address is consumed.
  task automatic walk(input int which, input int pc0, output int end_pc);
    int size, last, pc;
    logic [67:0] w;
    exp_t e;
    size = which ? 4 : 32;
    last = which ? 3 : 31;
    pc = pc0;
    end_pc = pc0;
    for (int n = 0; n < 64; n++) begin
      if (which != 0) adr_q_b.push_back(pc); else adr_q_a.push_back(pc);
      w = (which != 0) ? mem_b[pc] : mem_a[pc];
      if (w == '0) begin
        end_pc = pc;
        return;
      end
      e.word = w;
      e.pc   = 5'(pc);
      if (which != 0) exp_q_b.push_back(e); else exp_q_a.push_back(e);
      if (pc == last) begin
        end_pc = (pc + 1) % size;
        return;
      end
      pc = (pc + 1) % size;
    end
  endtask

  task automatic pulseLoad(input int which, input int pc);
    @(posedge clk); #1;
    if (which != 0) begin pc_load_b = 1'b1; pc_load_addr_b = 2'(pc); model_pc_b = pc; end
    else begin pc_load_a = 1'b1; pc_load_addr_a = 5'(pc); model_pc_a = pc; end
    @(posedge clk); #1;
    pc_load_a = 1'b0;
    pc_load_b = 1'b0;
  endtask

  task automatic pulseStart(input int which);
    @(posedge clk); #1;
    if (which != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic applyStimulus(input int which, input int load_pc);
    int end_pc;
    if (load_pc >= 0) pulseLoad(which, load_pc);
    walk(which, (which != 0) ? model_pc_b : model_pc_a, end_pc);
    if (which != 0) model_pc_b = end_pc; else model_pc_a = end_pc;
    pulseStart(which);
  endtask

  task automatic waitHalt(input int which, input int budget);
    int n;
    n = 0;
    while (((which != 0) ? halted_b : halted_a) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("halted", (which != 0) ? halted_b : halted_a, 1);
    repeat (4) @(negedge clk);
    checkOutput("inst_drain", (which != 0) ? exp_q_b.size() : exp_q_a.size(), 0);
    checkOutput("fetch_drain", (which != 0) ? adr_q_b.size() : adr_q_a.size(), 0);
  endtask

  task automatic waitValidA(input int budget);
    int n;
    n = 0;
    while (inst_valid_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("a_valid_seen", inst_valid_a, 1);
  endtask

  task automatic checkResetA(input string name);
    checkOutput(name, {inst_valid_a, busy_a, halted_a, pm_rd_a, pm_addr_a, opcode_a,
                       mode_a, op_a_a, op_b_a, inst_pc_a}, '0);
  endtask

  // Back-pressure driver for instance A, updated just after each rising edge.
  initial begin
    inst_ready_a = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       inst_ready_a = 1'b1;
        1:       inst_ready_a = ($urandom_range(0, 2) != 0);
        default: inst_ready_a = 1'b0;
      endcase
    end
  end

  // Monitor A: fetch addresses, held instruction (every HOLD cycle) and valid latency.
  initial begin
    int cyc, rd_cyc, a;
    logic prev_v;
    exp_t e;
    cyc = 0; rd_cyc = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        prev_v = 1'b0;
      end else begin
        if (pm_rd_a) begin
          rd_cyc = cyc;
          if (adr_q_a.size() == 0) flagUnexpected("a_fetch_addr", pm_addr_a);
          else begin
            a = adr_q_a.pop_front();
            checkOutput("a_fetch_addr", pm_addr_a, a);
          end
        end
        if (inst_valid_a) begin
          checkOutput("a_rd_in_hold", pm_rd_a, 0);
          if (!prev_v) checkOutput("a_latency", cyc - rd_cyc, 2);
          if (exp_q_a.size() == 0) flagUnexpected("a_inst", {opcode_a, inst_pc_a});
          else begin
            e = exp_q_a[0];
            checkOutput("a_inst", {opcode_a, mode_a, op_a_a, op_b_a, inst_pc_a},
                        {e.word[67:65], e.word[64], e.word[63:32], e.word[31:0], e.pc});
            if (inst_ready_a) void'(exp_q_a.pop_front());
          end
        end
        prev_v = inst_valid_a;
      end
    end
  end

  // Monitor B: same checks for the 3-cycle-latency instance.
  initial begin
    int cyc, rd_cyc, a;
    logic prev_v;
    exp_t e;
    cyc = 0; rd_cyc = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        prev_v = 1'b0;
      end else begin
        if (pm_rd_b) begin
          rd_cyc = cyc;
          if (adr_q_b.size() == 0) flagUnexpected("b_fetch_addr", pm_addr_b);
          else begin
            a = adr_q_b.pop_front();
            checkOutput("b_fetch_addr", pm_addr_b, a);
          end
        end
        if (inst_valid_b) begin
          if (!prev_v) checkOutput("b_latency", cyc - rd_cyc, 4);
          if (exp_q_b.size() == 0) flagUnexpected("b_inst", {opcode_b, inst_pc_b});
          else begin
            e = exp_q_b[0];
            checkOutput("b_inst", {opcode_b, mode_b, op_a_b, op_b_b, 3'b000, inst_pc_b},
                        {e.word[67:65], e.word[64], e.word[63:32], e.word[31:0], e.pc});
            if (inst_ready_b) void'(exp_q_b.pop_front());
          end
        end
        prev_v = inst_valid_b;
      end
    end
  end

  task automatic loadSpecProgram();
    for (int i = 0; i < 32; i++) mem_a[i] = randWord(0);
    mem_a[0] = 68'h9_00000000_00000003;
    mem_a[1] = 68'hD_0000000B_00000004;
    mem_a[2] = 68'h0_00000000_0000000B;
    mem_a[3] = 68'hB_00000000_00000005;
    mem_a[4] = '0;
  endtask

  initial begin
    int end_pc;
    checks = 0; failures = 0; ready_mode = 0;
    model_pc_a = 0; model_pc_b = 0;
    start_a = 0; pc_load_a = 0; pc_load_addr_a = '0;
    start_b = 0; pc_load_b = 0; pc_load_addr_b = '0; inst_ready_b = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetA("a_reset_state");
    checkOutput("b_reset_state", {inst_valid_b, busy_b, halted_b, pm_rd_b, pm_addr_b}, '0);
    rst_n = 1'b1;

    // Example program with 3 cycles of back-pressure on the first instruction.
    loadSpecProgram();
    ready_mode = 2;
    applyStimulus(0, -1);
    waitValidA(20);
    repeat (2) @(negedge clk);
    ready_mode = 0;
    waitHalt(0, 200);
    // Resume must refetch the end marker at pc 4 and halt again.
    applyStimulus(0, -1);
    waitHalt(0, 50);

    // Jump to 2 while the addr-0 read is in flight.
    pulseLoad(0, 0);
    adr_q_a.push_back(0);
    walk(0, 2, end_pc);
    model_pc_a = end_pc;
    pulseStart(0);
    @(posedge clk); #1;
    pc_load_a = 1'b1;
    pc_load_addr_a = 5'd2;
    @(posedge clk); #1;
    pc_load_a = 1'b0;
    waitHalt(0, 100);

    // Asynchronous reset while an instruction is being held.
    ready_mode = 2;
    applyStimulus(0, 0);
    waitValidA(20);
    #2 rst_n = 1'b0;
    #1 checkResetA("a_async_reset");
    exp_q_a.delete();
    adr_q_a.delete();
    model_pc_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("a_idle_after_reset", {busy_a, halted_a, pm_rd_a}, 0);
    ready_mode = 0;
    applyStimulus(0, -1);
    waitHalt(0, 200);

    // Random programs, random entry points or resumes, random back-pressure.
    ready_mode = 1;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 32; i++) mem_a[i] = randWord(8);
      applyStimulus(0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 31)) : -1);
      waitHalt(0, 3000);
    end

    // Short instance: last address 3, read latency 3; second run resumes from wrapped pc 0.
    for (int i = 0; i < 4; i++) mem_b[i] = randWord(0);
    applyStimulus(1, -1);
    waitHalt(1, 200);
    applyStimulus(1, -1);
    waitHalt(1, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
